// File: rtl/round_sequencer.sv
// Round sequencer: starts the safe-zone generator, runs a rating-scaled countdown, issues round end and win/lose.
// Optional ROUND_GRACE_STRICT_EN: a player who leaves the zone during the final grace window loses the round.
module round_sequencer #(
    parameter int RATING_WIDTH = 8,
    parameter int TIME_WIDTH   = 8,
    parameter int TICK_DIV     = 25000000,
    parameter int BASE_TICKS   = 200,
    parameter int STEP_TICKS   = 8,
    parameter int MIN_TICKS    = 40
`ifdef ROUND_GRACE_STRICT_EN
    ,
    parameter int GRACE_TICKS  = 5
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_regenerate_level,
    input  logic                    i_game_running,
    input  logic [RATING_WIDTH-1:0] i_current_rating,
    input  logic                    i_player_in_zone,
    output logic                    o_gen_start,
    input  logic                    i_gen_done,
    output logic                    o_ready,
    output logic                    o_round_ended,
    output logic                    o_is_win,
    output logic [TIME_WIDTH-1:0]   o_time_left,
    output logic                    o_busy
);

    localparam int CALC_W  = TIME_WIDTH + RATING_WIDTH + 1;
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GEN_WAIT = 3'd1,
        ST_ARMED    = 3'd2,
        ST_COUNT    = 3'd3,
        ST_END      = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [TIME_WIDTH-1:0]   len_r, len_s;
    logic [TIME_WIDTH-1:0]   time_left_r, time_left_s;
    logic [PRESC_W-1:0]      presc_r, presc_s;
    logic                    gen_start_r, gen_start_s;
    logic                    ready_r, ready_s;
    logic                    round_ended_r, round_ended_s;
    logic                    is_win_r, is_win_s;
    logic                    busy_r, busy_s;
`ifdef ROUND_GRACE_STRICT_EN
    logic                    grace_flag_r, grace_flag_s;
`endif

    // Round length; a product at or above the base saturates straight to the floor.
    function automatic logic [TIME_WIDTH-1:0] round_len(input logic [RATING_WIDTH-1:0] rating);
        logic [CALC_W-1:0] prod;
        logic [CALC_W-1:0] diff;
        prod = CALC_W'(rating) * CALC_W'(STEP_TICKS);
        diff = '0;
        if (prod >= CALC_W'(BASE_TICKS)) begin
            round_len = TIME_WIDTH'(MIN_TICKS);
        end else begin
            diff = CALC_W'(BASE_TICKS) - prod;
            if (diff < CALC_W'(MIN_TICKS)) begin
                round_len = TIME_WIDTH'(MIN_TICKS);
            end else begin
                round_len = TIME_WIDTH'(diff);
            end
        end
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_s       = state_r;
        len_s         = len_r;
        time_left_s   = time_left_r;
        presc_s       = presc_r;
        gen_start_s   = 1'b0;
        ready_s       = 1'b0;
        round_ended_s = 1'b0;
        is_win_s      = is_win_r;
`ifdef ROUND_GRACE_STRICT_EN
        grace_flag_s  = grace_flag_r;
`endif

        case (state_r)
            ST_IDLE: begin
                state_s = ST_IDLE;
            end
            ST_GEN_WAIT: begin
                if (i_gen_done) begin
                    time_left_s = len_r;
                    ready_s     = 1'b1;
                    state_s     = ST_ARMED;
                end else begin
                    state_s = ST_GEN_WAIT;
                end
            end
            ST_ARMED: begin
                presc_s = '0;
                if (i_game_running) begin
                    state_s = ST_COUNT;
`ifdef ROUND_GRACE_STRICT_EN
                    grace_flag_s = 1'b0;
`endif
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_COUNT: begin
`ifdef ROUND_GRACE_STRICT_EN
                if ((time_left_r <= TIME_WIDTH'(GRACE_TICKS)) && !i_player_in_zone) begin
                    grace_flag_s = 1'b1;
                end else begin
                    grace_flag_s = grace_flag_r;
                end
`endif
                if (!i_game_running) begin
                    presc_s = presc_r;
                end else if (presc_r == PRESC_MAX) begin
                    presc_s = '0;
                    // Saturate at zero so a stray tick can never wrap the counter.
                    if (time_left_r <= TIME_WIDTH'(1)) begin
                        time_left_s = '0;
                        state_s     = ST_END;
                    end else begin
                        time_left_s = time_left_r - TIME_WIDTH'(1);
                    end
                end else begin
                    presc_s = presc_r + PRESC_W'(1);
                end
            end
            ST_END: begin
                round_ended_s = 1'b1;
`ifdef ROUND_GRACE_STRICT_EN
                is_win_s      = i_player_in_zone & ~grace_flag_r;
`else
                is_win_s      = i_player_in_zone;
`endif
                state_s       = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A regenerate request restarts generation from any state, overriding a same-cycle gen_done.
        if (i_regenerate_level) begin
            state_s     = ST_GEN_WAIT;
            len_s       = round_len(i_current_rating);
            time_left_s = time_left_r;
            gen_start_s = 1'b1;
            ready_s     = 1'b0;
        end else begin
            len_s = len_s;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            len_r         <= '0;
            time_left_r   <= '0;
            presc_r       <= '0;
            gen_start_r   <= 1'b0;
            ready_r       <= 1'b0;
            round_ended_r <= 1'b0;
            is_win_r      <= 1'b0;
            busy_r        <= 1'b0;
`ifdef ROUND_GRACE_STRICT_EN
            grace_flag_r  <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            len_r         <= len_s;
            time_left_r   <= time_left_s;
            presc_r       <= presc_s;
            gen_start_r   <= gen_start_s;
            ready_r       <= ready_s;
            round_ended_r <= round_ended_s;
            is_win_r      <= is_win_s;
            busy_r        <= busy_s;
`ifdef ROUND_GRACE_STRICT_EN
            grace_flag_r  <= grace_flag_s;
`endif
        end
    end

    assign o_gen_start   = gen_start_r;
    assign o_ready       = ready_r;
    assign o_round_ended = round_ended_r;
    assign o_is_win      = is_win_r;
    assign o_time_left   = time_left_r;
    assign o_busy        = busy_r;

endmodule
